// File: rtl/i2s_dac_tx_pkg.sv
// Shared constants and state encoding for the I2S playback path.
// The sample width default and the frame-state enum live here so the FFT/pitch path can reuse them.
package audio_pkg;

    localparam int W             = 16;
    localparam int BITS_PER_HALF = 32;

    typedef enum logic [1:0] {
        WAIT_LEFT,
        SHIFT,
        PAD
    } tx_state_t;

endpackage

// File: rtl/i2s_dac_tx_if.sv
// Valid/ready stream that carries signed mono samples into the I2S transmitter.
interface i2s_dac_tx_if #(
    parameter int W = audio_pkg::W
) ();

    logic signed [W-1:0] sample_data;
    logic                sample_valid;
    logic                sample_ready;

    modport master (
        output sample_data,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/i2s_dac_tx_sample_fifo.sv
// Small circular sample buffer with an extra pointer bit to tell full from empty.
// The read side is show-ahead: dout always presents the oldest stored entry.
module sample_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wrPtr;
    logic [AW:0]  r_rdPtr;
    logic         w_doPush;
    logic         w_doPop;

    assign empty    = (r_wrPtr == r_rdPtr);
    assign full     = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_doPush = push && !full;
    assign w_doPop  = pop && !empty;
    assign dout     = r_mem[r_rdPtr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr[AW-1:0]] <= din;
        end
    end

    // Storage is left unreset; clearing the pointers is enough to discard its contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S transmitter for the WM8731 DAC: buffers mono samples and sends each one MSB-first
// on both channels of a DACLRCK frame, with the one-bit I2S delay after every LR edge.
module i2s_dac_tx #(
    parameter int W          = audio_pkg::W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    i2s_dac_tx_if.slave        sample_if,
    input  logic               daclrc,
    output logic               dacdat,
    output logic               underflow,
    output logic [7:0]         underflow_count
);

    import audio_pkg::*;

    localparam int                CNT_W    = $clog2(BITS_PER_HALF);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(W - 1);

    tx_state_t        r_state;
    logic             r_lrcQ;
    logic             r_dacdat;
    logic             r_underflow;
    logic [7:0]       r_underflowCnt;
    logic [W-1:0]     r_cur;
    logic [W-1:0]     r_shifter;
    logic [CNT_W-1:0] r_bitCnt;

    logic             w_leftStart;
    logic             w_rightStart;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [W-1:0]     w_fifoDout;
    logic [W-1:0]     w_nextCur;

    assign sample_if.sample_ready = !w_full && !reset;
    assign w_push       = sample_if.sample_valid && sample_if.sample_ready;
    assign w_leftStart  = r_lrcQ && !daclrc;
    assign w_rightStart = !r_lrcQ && daclrc;
    assign w_pop        = w_leftStart && !w_empty && !reset;
    assign w_nextCur    = w_empty ? '0 : w_fifoDout;

    assign dacdat          = r_dacdat;
    assign underflow       = r_underflow;
    assign underflow_count = r_underflowCnt;

    sample_fifo #(
        .W     (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .din   (sample_if.sample_data),
        .pop   (w_pop),
        .dout  (w_fifoDout),
        .full  (w_full),
        .empty (w_empty)
    );

    // Tracking daclrc straight through reset keeps a stale level from looking like an edge.
    always_ff @(posedge clk) begin
        r_lrcQ <= daclrc;
    end

    // The MSB goes out on the same edge that loads a word, so r_shifter keeps only the bits
    // still to send and r_bitCnt is the index of the bit currently on dacdat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= WAIT_LEFT;
            r_cur          <= '0;
            r_shifter      <= '0;
            r_bitCnt       <= '0;
            r_dacdat       <= 1'b0;
            r_underflow    <= 1'b0;
            r_underflowCnt <= '0;
        end else begin
            r_underflow <= 1'b0;
            if (w_leftStart) begin
                r_cur     <= w_nextCur;
                r_dacdat  <= w_nextCur[W-1];
                r_shifter <= w_nextCur << 1;
                r_bitCnt  <= LAST_BIT;
                r_state   <= SHIFT;
                if (w_empty) begin
                    r_underflow <= 1'b1;
                    if (r_underflowCnt != 8'hFF) begin
                        r_underflowCnt <= r_underflowCnt + 8'd1;
                    end
                end
            end else if (w_rightStart && (r_state != WAIT_LEFT)) begin
                r_dacdat  <= r_cur[W-1];
                r_shifter <= r_cur << 1;
                r_bitCnt  <= LAST_BIT;
                r_state   <= SHIFT;
            end else begin
                case (r_state)
                    SHIFT: begin
                        if (r_bitCnt == '0) begin
                            r_dacdat <= 1'b0;
                            r_state  <= PAD;
                        end else begin
                            r_dacdat  <= r_shifter[W-1];
                            r_shifter <= r_shifter << 1;
                            r_bitCnt  <= r_bitCnt - 1'b1;
                        end
                    end
                    default: begin
                        r_dacdat <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
